// File: rtl/oserdes_pkg.sv
// Shared types and sizing helpers for the word-to-slice output gearbox.
package oserdes_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Number of output slices carried by one input word.
    function automatic int slice_ratio(input int in_width, input int out_width);
        return in_width / out_width;
    endfunction

    // Slice counter width; a ratio of 1 still gets a one-bit counter.
    function automatic int cnt_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/gearbox_fifo2.sv
// Two-entry synchronous FIFO buffering input words ahead of the slicer.
module gearbox_fifo2 #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy tracking; simultaneous push and pop leave the count alone.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/oserdes_gearbox.sv
// Word-to-slice gearbox feeding the per-lane output serializers.
// Buffers two words, emits one slice per lane per CE cycle, and falls back
// to the idle pattern (flagging underflow) when the stream runs dry.
module oserdes_gearbox
    import oserdes_pkg::*;
#(
    parameter int                   CHANNELS     = 1,
    parameter int                   IN_WIDTH     = 32,
    parameter int                   OUT_WIDTH    = 8,
    parameter bit                   MSB_FIRST    = 1'b0,
    parameter logic [OUT_WIDTH-1:0] IDLE_PATTERN = 8'h00
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          CE,
    input  logic [CHANNELS*IN_WIDTH-1:0]  IN,
    input  logic                          IN_VALID,
    output logic                          IN_READY,
    output logic [CHANNELS*OUT_WIDTH-1:0] OUT,
    output logic                          OUT_ACTIVE,
    output logic                          UNDERFLOW
);

    localparam int RATIO   = slice_ratio(IN_WIDTH, OUT_WIDTH);
    localparam int CNT_W   = cnt_width(RATIO);
    localparam int WORD_W  = CHANNELS * IN_WIDTH;
    localparam int SLICE_W = CHANNELS * OUT_WIDTH;

    // The counter wraps to RATIO mod 2^CNT_W once the last slice has gone out.
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(RATIO);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [SLICE_W-1:0] IDLE_ALL = {CHANNELS{IDLE_PATTERN}};

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WORD_W-1:0]  word_q;
    logic [SLICE_W-1:0] out_q;
    logic               active_q;
    logic               underflow_q;

    logic [WORD_W-1:0]  fifo_rd_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic               at_last;
    logic               start_word;

    // Pick slice idx from every lane of a word, honouring the bit order.
    function automatic logic [SLICE_W-1:0] pick_slice(input logic [WORD_W-1:0] word,
                                                      input logic [CNT_W-1:0]  idx);
        logic [SLICE_W-1:0] res;
        int                 phys;
        res  = '0;
        phys = MSB_FIRST ? (RATIO - 1 - int'(idx)) : int'(idx);
        for (int k = 0; k < CHANNELS; k++) begin
            res[k*OUT_WIDTH +: OUT_WIDTH] = word[k*IN_WIDTH + phys*OUT_WIDTH +: OUT_WIDTH];
        end
        return res;
    endfunction

    assign IN_READY   = RESET_N && !fifo_full;
    assign fifo_push  = IN_VALID && IN_READY;
    assign at_last    = (cnt_q == LAST_CNT);
    assign start_word = !fifo_empty && ((state_q == IDLE) || at_last);
    assign fifo_pop   = CE && start_word;

    gearbox_fifo2 #(
        .WIDTH (WORD_W)
    ) u_fifo (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .push    (fifo_push),
        .wr_data (IN),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Slice sequencer: advances only on CE, underflow pulse clears on any edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            out_q       <= IDLE_ALL;
            active_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= 1'b0;
            if (CE) begin
                if (start_word) begin
                    word_q   <= fifo_rd_data;
                    out_q    <= pick_slice(fifo_rd_data, '0);
                    active_q <= 1'b1;
                    cnt_q    <= CNT_ONE;
                    state_q  <= SHIFT;
                end else if ((state_q == SHIFT) && !at_last) begin
                    out_q <= pick_slice(word_q, cnt_q);
                    cnt_q <= cnt_q + CNT_ONE;
                end else begin
                    out_q    <= IDLE_ALL;
                    active_q <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= IDLE;
                    if (state_q == SHIFT) underflow_q <= 1'b1;
                end
            end
        end
    end

    assign OUT        = out_q;
    assign OUT_ACTIVE = active_q;
    assign UNDERFLOW  = underflow_q;

endmodule

// File: tb/tb_oserdes_gearbox.sv
// Bench for oserdes_gearbox: two instances (1 lane LSB-first idle 00,
// 2 lanes MSB-first idle 55) checked against hand tables and a queue model.
module tb_oserdes_gearbox;

    logic        CLK = 1'b0;
    logic        RESET_N;

    logic        ce0, vld0, rdy0, act0, uf0;
    logic [31:0] in0;
    logic [7:0]  out0;

    logic        ce1, vld1, rdy1, act1, uf1;
    logic [63:0] in1;
    logic [15:0] out1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    oserdes_gearbox #(
        .CHANNELS     (1),
        .IN_WIDTH     (32),
        .OUT_WIDTH    (8),
        .MSB_FIRST    (1'b0),
        .IDLE_PATTERN (8'h00)
    ) dut0 (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .CE         (ce0),
        .IN         (in0),
        .IN_VALID   (vld0),
        .IN_READY   (rdy0),
        .OUT        (out0),
        .OUT_ACTIVE (act0),
        .UNDERFLOW  (uf0)
    );

    oserdes_gearbox #(
        .CHANNELS     (2),
        .IN_WIDTH     (32),
        .OUT_WIDTH    (8),
        .MSB_FIRST    (1'b1),
        .IDLE_PATTERN (8'h55)
    ) dut1 (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .CE         (ce1),
        .IN         (in1),
        .IN_VALID   (vld1),
        .IN_READY   (rdy1),
        .OUT        (out1),
        .OUT_ACTIVE (act1),
        .UNDERFLOW  (uf1)
    );

    // Reference model: a queue of accepted words and a queue of slices still
    // to be shown for the word in flight.
    logic [63:0] m_q   [2][$];
    logic [15:0] m_rem [2][$];
    logic [15:0] m_out [2];
    logic        m_act [2];
    logic        m_uf  [2];

    function automatic logic [15:0] idle_of(input int d);
        return (d == 0) ? 16'h0000 : 16'h5555;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_q[d].delete();
            m_rem[d].delete();
            m_out[d] = idle_of(d);
            m_act[d] = 1'b0;
            m_uf[d]  = 1'b0;
        end
    endtask

    task automatic model_edge(input int d);
        logic        ce, vld, acc;
        logic [63:0] w_in, w, s;
        int          lanes, phys;
        ce    = (d == 0) ? ce0 : ce1;
        vld   = (d == 0) ? vld0 : vld1;
        w_in  = (d == 0) ? {32'h0, in0} : in1;
        lanes = (d == 0) ? 1 : 2;
        acc   = vld && (m_q[d].size() < 2);
        m_uf[d] = 1'b0;
        if (ce) begin
            if (m_rem[d].size() > 0) begin
                m_out[d] = m_rem[d].pop_front();
            end else if (m_q[d].size() > 0) begin
                w = m_q[d].pop_front();
                for (int i = 0; i < 4; i++) begin
                    s = '0;
                    for (int k = 0; k < lanes; k++) begin
                        phys = (d == 1) ? (3 - i) : i;
                        s = s | (((w >> (k*32 + phys*8)) & 64'hFF) << (k*8));
                    end
                    m_rem[d].push_back(s[15:0]);
                end
                m_out[d] = m_rem[d].pop_front();
                m_act[d] = 1'b1;
            end else begin
                if (m_act[d]) m_uf[d] = 1'b1;
                m_out[d] = idle_of(d);
                m_act[d] = 1'b0;
            end
        end
        if (acc) m_q[d].push_back(w_in);
    endtask

    task automatic compare_all();
        check("m_out0", {56'h0, out0}, {56'h0, m_out[0][7:0]});
        check("m_act0", {63'h0, act0}, {63'h0, m_act[0]});
        check("m_uf0",  {63'h0, uf0},  {63'h0, m_uf[0]});
        check("m_rdy0", {63'h0, rdy0}, {63'h0, RESET_N && (m_q[0].size() < 2)});
        check("m_out1", {48'h0, out1}, {48'h0, m_out[1]});
        check("m_act1", {63'h0, act1}, {63'h0, m_act[1]});
        check("m_uf1",  {63'h0, uf1},  {63'h0, m_uf[1]});
        check("m_rdy1", {63'h0, rdy1}, {63'h0, RESET_N && (m_q[1].size() < 2)});
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RESET_N) begin
            model_edge(0);
            model_edge(1);
        end
        #1;
        compare_all();
    endtask

    typedef struct {
        logic        ce;
        logic        vld;
        logic [31:0] data;
        logic [7:0]  out;
        logic        act;
        logic        uf;
        logic        rdy;
    } vec_t;

    function automatic vec_t mk(input logic ce, input logic vld, input logic [31:0] data,
                                input logic [7:0] out, input logic act, input logic uf,
                                input logic rdy);
        vec_t v;
        v.ce = ce; v.vld = vld; v.data = data;
        v.out = out; v.act = act; v.uf = uf; v.rdy = rdy;
        return v;
    endfunction

    vec_t tbl [36];

    initial begin
        logic [7:0] b, a;

        // Basic + back-to-back
        tbl[0]  = mk(1, 1, 32'h44332211, 8'h00, 0, 0, 1);
        tbl[1]  = mk(1, 1, 32'h88776655, 8'h11, 1, 0, 1);
        for (int i = 2; i <= 8; i++) tbl[i] = mk(1, 0, 32'h0, 8'(8'h11 * i), 1, 0, 1);
        tbl[9]  = mk(1, 0, 32'h0, 8'h00, 0, 1, 1);
        tbl[10] = mk(1, 0, 32'h0, 8'h00, 0, 0, 1);
        // CE gaps
        tbl[11] = mk(1, 1, 32'hDDCCBBAA, 8'h00, 0, 0, 1);
        tbl[12] = mk(0, 0, 32'h0, 8'h00, 0, 0, 1);
        for (int i = 13; i <= 20; i++)
            tbl[i] = mk(i % 2 == 1, 0, 32'h0, 8'(8'hAA + 8'h11 * ((i - 13) / 2)), 1, 0, 1);
        tbl[21] = mk(1, 0, 32'h0, 8'h00, 0, 1, 1);
        tbl[22] = mk(0, 0, 32'h0, 8'h00, 0, 0, 1);
        // Fill to full with CE low, third word refused
        tbl[23] = mk(0, 1, 32'h44332211, 8'h00, 0, 0, 1);
        tbl[24] = mk(0, 1, 32'h88776655, 8'h00, 0, 0, 0);
        tbl[25] = mk(0, 1, 32'hDEADBEEF, 8'h00, 0, 0, 0);
        tbl[26] = mk(1, 0, 32'h0, 8'h11, 1, 0, 1);
        for (int i = 27; i <= 33; i++) tbl[i] = mk(1, 0, 32'h0, 8'(8'h11 * (i - 25)), 1, 0, 1);
        tbl[34] = mk(1, 0, 32'h0, 8'h00, 0, 1, 1);
        tbl[35] = mk(1, 0, 32'h0, 8'h00, 0, 0, 1);

        RESET_N = 1'b0;
        ce0 = 0; vld0 = 0; in0 = '0;
        ce1 = 0; vld1 = 0; in1 = '0;
        model_reset();
        #12;
        check("rst_out0", {56'h0, out0}, 64'h00);
        check("rst_act0", {63'h0, act0}, 64'h0);
        check("rst_uf0",  {63'h0, uf0},  64'h0);
        check("rst_rdy0", {63'h0, rdy0}, 64'h0);
        check("rst_out1", {48'h0, out1}, 64'h5555);
        RESET_N = 1'b1;

        // Table phase on dut0; dut1 sits idle showing its pattern
        ce1 = 1'b1;
        for (int i = 0; i < 36; i++) begin
            ce0 = tbl[i].ce; vld0 = tbl[i].vld; in0 = tbl[i].data;
            tick();
            check($sformatf("row%0d_out", i), {56'h0, out0}, {56'h0, tbl[i].out});
            check($sformatf("row%0d_act", i), {63'h0, act0}, {63'h0, tbl[i].act});
            check($sformatf("row%0d_uf", i),  {63'h0, uf0},  {63'h0, tbl[i].uf});
            check($sformatf("row%0d_rdy", i), {63'h0, rdy0}, {63'h0, tbl[i].rdy});
            if (i < 10) begin
                check($sformatf("idle1_out%0d", i), {48'h0, out1}, 64'h5555);
                check($sformatf("idle1_uf%0d", i),  {63'h0, uf1},  64'h0);
                check($sformatf("idle1_act%0d", i), {63'h0, act1}, 64'h0);
            end
        end

        // MSB-first, two lanes in lockstep
        ce0 = 1'b1; vld0 = 1'b0;
        in1 = {32'hB3B2B1B0, 32'hA3A2A1A0}; vld1 = 1'b1;
        tick();
        vld1 = 1'b0;
        check("msb_accept_out", {48'h0, out1}, 64'h5555);
        for (int k = 0; k < 4; k++) begin
            tick();
            b = 8'hB3 - 8'(k);
            a = 8'hA3 - 8'(k);
            check($sformatf("msb_slice%0d", k), {48'h0, out1}, {48'h0, b, a});
            check($sformatf("msb_act%0d", k), {63'h0, act1}, 64'h1);
        end
        tick();
        check("msb_end_out", {48'h0, out1}, 64'h5555);
        check("msb_end_uf",  {63'h0, uf1},  64'h1);
        tick();
        check("msb_uf_clr",  {63'h0, uf1},  64'h0);

        // Reset in the middle of a word with a second word queued
        in0 = 32'h44332211; vld0 = 1'b1;
        tick();
        in0 = 32'h88776655;
        tick();
        vld0 = 1'b0;
        tick();
        check("pre_rst_out", {56'h0, out0}, 64'h22);
        #2 RESET_N = 1'b0;
        #1;
        check("mid_rst_out", {56'h0, out0}, 64'h00);
        check("mid_rst_act", {63'h0, act0}, 64'h0);
        check("mid_rst_rdy", {63'h0, rdy0}, 64'h0);
        check("mid_rst_out1", {48'h0, out1}, 64'h5555);
        model_reset();
        tick();
        tick();
        RESET_N = 1'b1;
        #1;
        check("post_rst_rdy", {63'h0, rdy0}, 64'h1);
        in0 = 32'h04030201; vld0 = 1'b1;
        tick();
        vld0 = 1'b0;
        check("post_rst_idle", {56'h0, out0}, 64'h00);
        tick();
        check("post_rst_first", {56'h0, out0}, 64'h01);
        tick();
        check("post_rst_second", {56'h0, out0}, 64'h02);

        // Randomised traffic against the model, sweeping input density
        for (int blk = 0; blk < 8; blk++) begin
            for (int c = 0; c < 250; c++) begin
                ce0  = (blk % 2 == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
                ce1  = ($urandom_range(0, 4) != 0);
                vld0 = ($urandom_range(0, 7) < blk + 1);
                vld1 = ($urandom_range(0, 7) < 8 - blk);
                in0  = $urandom;
                in1  = {$urandom, $urandom};
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
